seg_scan_driver: RTL and testbench

Downstream display stage of the digital clock system. Takes eight BCD digits (clock or alarm time, selected upstream) plus per-digit blink flags for set mode. Drives the 8-digit common-anode seven-segment panel via time-multiplexed scanning, with frame-synchronous snapshot (no tearing), ghost blanking between digits, and a 2 Hz blink for fields being edited.

---
 rtl/seg_scan_driver.sv | 115 +++++++++++
 tb/tb_seg_scan_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver with frame snapshot, ghost blanking and blink.
// Optional macro LEADING_ZERO_BLANK_EN blanks digit 7 when its snapshot nibble is zero.
module seg_scan_driver #(
   parameter int unsigned SCAN_DIV  = 6250,
   parameter int unsigned BLINK_DIV = 2000,
   parameter int unsigned GHOST     = 8
) (
   input  logic        clk_50m,
   input  logic        cr,
   input  logic        en,
   input  logic [31:0] digits,
   input  logic [7:0]  blink_mask,
   input  logic        pm_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [7:0]  pos,
   output logic        frame_start
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] GHOST_W    = DW'(GHOST);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [2:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic [31:0]   snap_digits;
   logic [7:0]    snap_mask;

   logic       tick;
   logic       wrap;
   logic       slot_on;
   logic [3:0] cur_nib;
   logic [6:0] cur_seg;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h3F;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   always_comb begin
      tick    = (div_cnt == DIV_LAST);
      wrap    = tick && (idx == 3'd7);
      // First GHOST cycles of each slot keep every anode off to hide the previous digit
      slot_on = (div_cnt >= GHOST_W);
      cur_nib = snap_digits[idx*4 +: 4];
      cur_seg = decode(cur_nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx == 3'd7 && cur_nib == 4'h0) begin
         cur_seg = 7'h7F;
      end
`endif
      if (snap_mask[idx] && blink_phase) begin
         cur_seg = 7'h7F;
      end
   end

   always_ff @(posedge clk_50m or posedge cr) begin
      if (cr) begin
         div_cnt     <= '0;
         idx         <= 3'd0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         snap_digits <= 32'hFFFF_FFFF;
         snap_mask   <= 8'h00;
         seg         <= 7'h7F;
         dp          <= 1'b1;
         pos         <= 8'hFF;
         frame_start <= 1'b0;
      end else if (en) begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            idx <= idx + 3'd1;
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
         // Inputs are captured only at the frame boundary so a frame never mixes old and new data
         if (wrap) begin
            snap_digits <= digits;
            snap_mask   <= blink_mask;
         end
         frame_start <= wrap;
         pos         <= slot_on ? ~(8'd1 << idx) : 8'hFF;
         seg         <= cur_seg;
         dp          <= ~((idx == 3'd0) && pm_in && slot_on);
      end else begin
         frame_start <= 1'b0;
         pos         <= 8'hFF;
         seg         <= 7'h7F;
         dp          <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: expected frames are queued at each frame start
// and compared sample by sample as the driver scans them out.
module tb_seg_scan_driver;

   localparam int unsigned SD = 4;
   localparam int unsigned BD = 4;
   localparam int unsigned GH = 1;
   localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

   logic        clk_50m = 1'b0;
   logic        cr;
   logic        en;
   logic [31:0] digits;
   logic [7:0]  blink_mask;
   logic        pm_in;
   logic [6:0]  seg;
   logic        dp;
   logic [7:0]  pos;
   logic        frame_start;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0] pos;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] snap_d;
   logic [7:0]  snap_m;
   logic        snap_pm;
   int          frame_no;

   always #10 clk_50m = ~clk_50m;

   seg_scan_driver #(
      .SCAN_DIV  (SD),
      .BLINK_DIV (BD),
      .GHOST     (GH)
   ) dut (
      .clk_50m     (clk_50m),
      .cr          (cr),
      .en          (en),
      .digits      (digits),
      .blink_mask  (blink_mask),
      .pm_in       (pm_in),
      .seg         (seg),
      .dp          (dp),
      .pos         (pos),
      .frame_start (frame_start)
   );

   function automatic logic [6:0] dec_ref(input logic [3:0] n, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
      if (slot == 7 && n == 4'h0) return 7'h7F;
`endif
      return DEC[n];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Expected scan-out of one whole frame from the bench's own view of the snapshot
   task automatic push_frame();
      for (int k = 1; k <= 32; k++) begin
         int   slot;
         int   d;
         int   ph;
         exp_t e;
         slot  = (k - 1) / 4;
         d     = (k - 1) % 4;
         ph    = ((frame_no * 8 + slot) / BD) % 2;
         e.pos = (d < GH) ? 8'hFF : ~(8'd1 << slot);
         e.seg = (snap_m[slot] && ph == 1) ? 7'h7F : dec_ref(snap_d[slot*4 +: 4], slot);
         e.dp  = !(slot == 0 && snap_pm && d >= GH);
         sb.push_back(e);
      end
   endtask

   // Called at a sample where frame_start has just been seen high
   task automatic run_frame(input string tag, input logic [31:0] nd, input logic [7:0] nm,
                            input logic npm, input bit freeze);
      bit fs_bad = 0;
      push_frame();
      for (int k = 1; k <= 32; k++) begin
         exp_t e;
         @(negedge clk_50m);
         e = sb.pop_front();
         chk($sformatf("%s_s%0d", tag, k), {16'h0, pos, seg, dp}, {16'h0, e});
         if (k < 32 && frame_start !== 1'b0) fs_bad = 1;
         if (k == 10 && freeze) begin
            en = 1'b0;
            for (int j = 0; j < 20; j++) begin
               @(negedge clk_50m);
               chk($sformatf("%s_frz%0d", tag, j), {15'h0, pos, seg, dp, frame_start},
                   {15'h0, 8'hFF, 7'h7F, 1'b1, 1'b0});
            end
            en = 1'b1;
         end
         if (k == 16) begin
            digits     = nd;
            blink_mask = nm;
            pm_in      = npm;
         end
      end
      chk({tag, "_fs"}, {30'h0, frame_start, fs_bad}, 32'h2);
      frame_no++;
      snap_d  = nd;
      snap_m  = nm;
      snap_pm = npm;
   endtask

   // Frame 0 after reset release: dark, ends with the first frame_start after 32 cycles
   task automatic wait_first(input string tag);
      int n = 0;
      bit lit = 0;
      while (n < 40) begin
         @(negedge clk_50m);
         n++;
         if (seg !== 7'h7F) lit = 1;
         if (frame_start === 1'b1) break;
      end
      chk({tag, "_len"}, n, 32);
      chk({tag, "_dark"}, {31'h0, lit}, 32'h0);
      frame_no = 1;
      snap_d   = digits;
      snap_m   = blink_mask;
      snap_pm  = pm_in;
   endtask

   initial begin
      cr         = 1'b1;
      en         = 1'b0;
      digits     = 32'h0;
      blink_mask = 8'h00;
      pm_in      = 1'b0;
      frame_no   = 0;
      snap_d     = 32'hFFFF_FFFF;
      snap_m     = 8'h00;
      snap_pm    = 1'b0;
      repeat (3) @(negedge clk_50m);
      chk("reset", {15'h0, pos, seg, dp, frame_start}, {15'h0, 8'hFF, 7'h7F, 1'b1, 1'b0});

      cr     = 1'b0;
      en     = 1'b1;
      digits = 32'h1234_5678;
      wait_first("frame0");

      run_frame("f1", 32'h0000_0009, 8'h00, 1'b0, 1'b0);
      run_frame("f2", 32'h0000_0009, 8'h33, 1'b1, 1'b0);
      run_frame("f3", 32'h0000_0009, 8'h33, 1'b1, 1'b1);
      run_frame("f4", 32'h0000_00AB, 8'h00, 1'b0, 1'b0);

      repeat (12) @(negedge clk_50m);
      cr = 1'b1;
      #1;
      chk("cr_mid", {15'h0, pos, seg, dp, frame_start}, {15'h0, 8'hFF, 7'h7F, 1'b1, 1'b0});
      repeat (2) @(negedge clk_50m);
      cr = 1'b0;
      wait_first("after_cr");
      run_frame("fab", 32'h0000_00AB, 8'h00, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
